ifetch_queue: RTL and testbench

//  Fetch stage directly downstream of the program counter.
//  - Issues ins_address to instruction memory over a valid/ready request channel.
//  - Holds returning instructions in a QDEPTH-entry in-order reservation queue.
//  - Presents {pc, instr} to decode with a valid/ready handshake.
//  - Drives pc_hold back to the PC; flushes everything on a taken branch.

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/ifq_storage.sv | 67 ++++++
 rtl/ifetch_queue.sv | 109 ++++++++++
 tb/tb_ifetch_queue.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifetch_pkg;

  localparam int IFQ_ADDR_W = 32;
  localparam int IFQ_DATA_W = 32;
  localparam int IFQ_QDEPTH = 4;
  localparam int IFQ_PTR_W  = $clog2(IFQ_QDEPTH);

  localparam logic [IFQ_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [IFQ_ADDR_W-1:0] pc;
    logic [IFQ_DATA_W-1:0] instr;
    logic                  pending;
    logic                  filled;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// In-order slot array: allocate at tail, fill at fill pointer,
// dequeue at head; flush invalidates every slot and rewinds pointers.
module ifq_storage
  import ifetch_pkg::*;
#(
  parameter int QDEPTH = IFQ_QDEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  alloc_en,
  input  logic [IFQ_ADDR_W-1:0] alloc_pc,
  input  logic                  fill_en,
  input  logic [IFQ_DATA_W-1:0] fill_data,
  input  logic                  deq_en,
  output logic                  head_filled,
  output logic [IFQ_ADDR_W-1:0] head_pc,
  output logic [IFQ_DATA_W-1:0] head_instr
);

  localparam int PW = $clog2(QDEPTH);

  ifq_entry_t    slot [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] fill;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < QDEPTH; i++) slot[i] <= '0;
      head <= '0;
      tail <= '0;
      fill <= '0;
    end else if (flush) begin
      for (int i = 0; i < QDEPTH; i++) begin
        slot[i].pending <= 1'b0;
        slot[i].filled  <= 1'b0;
      end
      head <= '0;
      tail <= '0;
      fill <= '0;
    end else begin
      if (alloc_en) begin
        slot[tail].pc      <= alloc_pc;
        slot[tail].pending <= 1'b1;
        slot[tail].filled  <= 1'b0;
        tail               <= tail + 1'b1;
      end
      // only a slot still waiting on IMEM may take data
      if (fill_en && slot[fill].pending) begin
        slot[fill].instr   <= fill_data;
        slot[fill].pending <= 1'b0;
        slot[fill].filled  <= 1'b1;
        fill               <= fill + 1'b1;
      end
      if (deq_en) begin
        slot[head].filled <= 1'b0;
        head              <= head + 1'b1;
      end
    end
  end

  assign head_filled = slot[head].filled;
  assign head_pc     = slot[head].pc;
  assign head_instr  = slot[head].instr;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: IMEM request issue, in-order response queue, decode handshake.
// Define IFQ_PERF_EN to build the stall/flush performance counters.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = IFQ_ADDR_W,
  parameter int DATA_W = IFQ_DATA_W,
  parameter int QDEPTH = IFQ_QDEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ins_address,
  input  logic              branch_en,
  output logic              pc_hold,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  localparam int PW = $clog2(QDEPTH);

  logic [PW:0]   alloc_cnt;
  logic [PW:0]   pend_cnt;
  logic [PW+1:0] drop_cnt;
  logic          fire;
  logic          fill_en;
  logic          deq;

  assign imem_req_valid = reset & ~branch_en
                        & (alloc_cnt < (PW+1)'(QDEPTH));
  assign imem_req_addr  = ins_address;
  assign fire           = imem_req_valid & imem_req_ready;
  assign pc_hold        = ~fire;

  // responses owed to flushed requests are swallowed first
  assign fill_en = reset & imem_rsp_valid & ~branch_en
                 & (drop_cnt == '0);
  assign deq     = instr_valid & instr_ready;

  ifq_storage #(
    .QDEPTH (QDEPTH)
  ) u_store (
    .clk         (clk),
    .reset       (reset),
    .flush       (branch_en),
    .alloc_en    (fire),
    .alloc_pc    (ins_address),
    .fill_en     (fill_en),
    .fill_data   (imem_rsp_data),
    .deq_en      (deq),
    .head_filled (instr_valid),
    .head_pc     (instr_pc),
    .head_instr  (instr_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
    end else if (branch_en) begin
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= drop_cnt + (PW+2)'(pend_cnt)
                 - (PW+2)'(imem_rsp_valid);
    end else begin
      alloc_cnt <= alloc_cnt + (PW+1)'(fire) - (PW+1)'(deq);
      pend_cnt  <= pend_cnt + (PW+1)'(fire) - (PW+1)'(fill_en);
      if (imem_rsp_valid && drop_cnt != '0)
        drop_cnt <= drop_cnt - 1'b1;
    end
  end

`ifdef IFQ_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + {31'd0, pc_hold};
      flush_q <= flush_q + {31'd0, branch_en};
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

  a_rsp_owed : assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (drop_cnt != '0) || (pend_cnt != '0));

  a_drop_max : assert property (@(posedge clk) disable iff (!reset)
    drop_cnt <= (PW+2)'(QDEPTH));

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a small PC and IMEM model.
// Expected values are hand-computed per scenario.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ins_address = '0;
  logic        branch_en = 1'b0;
  logic        pc_hold;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fire = 0;
  bit          auto_rsp = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] s0, f0;

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .ins_address    (ins_address),
    .branch_en      (branch_en),
    .pc_hold        (pc_hold),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic settle();
    #1;
  endtask

  // one clock: sample handshake mid-cycle, then update PC and IMEM model
  task automatic cyc();
    logic        f;
    logic        b;
    logic [31:0] a;
    @(negedge clk);
    f = imem_req_valid & imem_req_ready;
    a = imem_req_addr;
    b = branch_en;
    if (f) n_fire++;
    @(posedge clk);
    #1;
    if (b) ins_address = br_target;
    else if (f) ins_address = ins_address + 32'd4;
    branch_en = 1'b0;
    if (auto_rsp && f && reset) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mk(a);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    branch_en   = 1'b0;
    instr_ready = 1'b0;
    cyc();
    cyc();
    ins_address = '0;
    reset       = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // reset held 3 cycles
    imem_req_ready = 1'b1;
    auto_rsp = 1'b1;
    repeat (3) cyc();
    settle();
    chk("rst_ivalid", 32'(instr_valid), 32'd0);
    chk("rst_rvalid", 32'(imem_req_valid), 32'd0);
    chk("rst_hold", 32'(pc_hold), 32'd1);
    chk("rst_idata", instr_data, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);

    // release: request at 0x0 immediately
    reset = 1'b1;
    instr_ready = 1'b1;
    settle();
    chk("rel_rvalid", 32'(imem_req_valid), 32'd1);
    chk("rel_raddr", imem_req_addr, 32'h0);
    chk("rel_hold", 32'(pc_hold), 32'd0);

    // streaming: one instruction per cycle after fill
    cyc(); settle();
    chk("lat_ivalid", 32'(instr_valid), 32'd0);
    cyc(); settle();
    chk("s0_valid", 32'(instr_valid), 32'd1);
    chk("s0_pc", instr_pc, 32'h0);
    chk("s0_data", instr_data, mk(32'h0));
    cyc(); settle();
    chk("s1_pc", instr_pc, 32'h4);
    chk("s1_data", instr_data, mk(32'h4));
    cyc(); settle();
    chk("s2_pc", instr_pc, 32'h8);
    chk("s2_valid", 32'(instr_valid), 32'd1);

    // decode stalled: fills to 4 and holds
    do_reset();
    n_fire = 0;
    repeat (8) cyc();
    settle();
    chk("full_fires", 32'(n_fire), 32'd4);
    chk("full_rvalid", 32'(imem_req_valid), 32'd0);
    chk("full_hold", 32'(pc_hold), 32'd1);
    chk("full_headpc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    settle();
    chk("full_deq_noreq", 32'(imem_req_valid), 32'd0);
    cyc();
    instr_ready = 1'b0;
    settle();
    chk("refill_rvalid", 32'(imem_req_valid), 32'd1);
    chk("refill_raddr", imem_req_addr, 32'h10);
    chk("refill_headpc", instr_pc, 32'h4);
    cyc(); settle();
    chk("refull_rvalid", 32'(imem_req_valid), 32'd0);
    chk("refull_fires", 32'(n_fire), 32'd5);

    // flush with 2 pending and a response in the flush cycle
    do_reset();
    auto_rsp = 1'b0;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    cyc();
    cyc();
    imem_req_ready = 1'b0;
    branch_en = 1'b1;
    br_target = 32'h40;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = mk(32'h0);
    settle();
    chk("br_noreq", 32'(imem_req_valid), 32'd0);
    cyc();
    imem_req_ready = 1'b1;
    settle();
    chk("br_ivalid", 32'(instr_valid), 32'd0);
    chk("br_drop", 32'(dut.drop_cnt), 32'd1);
    chk("br_raddr", imem_req_addr, 32'h40);
    cyc();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = mk(32'h4);
    settle();
    chk("stale_ivalid", 32'(instr_valid), 32'd0);
    cyc();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = mk(32'h40);
    settle();
    chk("drop_done", 32'(dut.drop_cnt), 32'd0);
    chk("drop_ivalid", 32'(instr_valid), 32'd0);
    cyc(); settle();
    chk("tgt_valid", 32'(instr_valid), 32'd1);
    chk("tgt_pc", instr_pc, 32'h40);
    chk("tgt_data", instr_data, mk(32'h40));
    cyc(); settle();
    chk("tgt_gone", 32'(instr_valid), 32'd0);

    // reset mid-operation with 3 filled slots
    do_reset();
    auto_rsp = 1'b1;
    imem_req_ready = 1'b1;
    repeat (3) cyc();
    imem_req_ready = 1'b0;
    cyc(); settle();
    chk("mr_valid", 32'(instr_valid), 32'd1);
    chk("mr_alloc", 32'(dut.alloc_cnt), 32'd3);
    reset = 1'b0;
    cyc(); settle();
    chk("mr_ivalid", 32'(instr_valid), 32'd0);
    chk("mr_idata", instr_data, 32'd0);
    chk("mr_ipc", instr_pc, 32'd0);
    chk("mr_head", 32'(dut.u_store.head), 32'd0);
    chk("mr_tail", 32'(dut.u_store.tail), 32'd0);
    chk("mr_fill", 32'(dut.u_store.fill), 32'd0);
    chk("mr_acnt", 32'(dut.alloc_cnt), 32'd0);
    chk("mr_hold", 32'(pc_hold), 32'd1);
    reset = 1'b1;
    ins_address = '0;

    // performance counters: 3 stalls + 2 flush cycles
    settle();
    s0 = perf_stall_cnt;
    f0 = perf_flush_cnt;
    repeat (3) cyc();
    branch_en = 1'b1;
    cyc();
    branch_en = 1'b1;
    cyc();
    settle();
`ifdef IFQ_PERF_EN
    chk("perf_stall", perf_stall_cnt - s0, 32'd5);
    chk("perf_flush", perf_flush_cnt - f0, 32'd2);
`else
    chk("perf_stall", perf_stall_cnt, 32'd0);
    chk("perf_flush", perf_flush_cnt, 32'd0);
    chk("perf_stall0", s0, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
